id_ex_fwd_stage: RTL and testbench

// ID/EX pipeline register with operand bypass and load-use hazard detection for the 16-bit pipelined CPU.

---
 rtl/cpu_pkg.sv | 17 +
 rtl/id_ex_fwd_stage_if.sv | 50 +++++
 rtl/id_ex_fwd_stage_fwd_mux.sv | 41 ++++
 rtl/id_ex_fwd_stage.sv | 100 ++++++++++
 tb/tb_id_ex_fwd_stage.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants and the operand-bypass source encoding.
package cpu_pkg;

  localparam int unsigned DATA_W      = 16;
  localparam int unsigned ADDR_W      = 4;
  localparam int unsigned STALL_CNT_W = 16;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    FWD_RF,
    FWD_EX,
    FWD_MEM,
    FWD_ZERO
  } fwd_sel_e;

endpackage

// File: rtl/id_ex_fwd_stage_if.sv
// ID/EX boundary bundle: decode fields and bypass sources in, EX-stage fields and stall out.
interface id_ex_fwd_stage_if
  #(parameter int unsigned DATA_W      = cpu_pkg::DATA_W,
    parameter int unsigned ADDR_W      = cpu_pkg::ADDR_W,
    parameter int unsigned STALL_CNT_W = cpu_pkg::STALL_CNT_W);

  logic                   id_valid;
  logic [ADDR_W-1:0]      id_src0_addr;
  logic [ADDR_W-1:0]      id_src1_addr;
  logic                   id_src0_used;
  logic                   id_src1_used;
  logic [ADDR_W-1:0]      id_dst_addr;
  logic                   id_we;
  logic                   id_is_load;
  logic [DATA_W-1:0]      rf_p0;
  logic [DATA_W-1:0]      rf_p1;
  logic [DATA_W-1:0]      ex_result;
  logic                   mem_valid;
  logic                   mem_we;
  logic [ADDR_W-1:0]      mem_dst_addr;
  logic [DATA_W-1:0]      mem_fwd_data;
  logic                   freeze;
  logic                   flush;

  logic                   id_stall;
  logic                   ex_valid;
  logic [DATA_W-1:0]      ex_op0;
  logic [DATA_W-1:0]      ex_op1;
  logic [ADDR_W-1:0]      ex_dst_addr;
  logic                   ex_we;
  logic                   ex_is_load;
  logic [STALL_CNT_W-1:0] stall_cnt;

  modport master (
    output id_valid, id_src0_addr, id_src1_addr, id_src0_used, id_src1_used,
           id_dst_addr, id_we, id_is_load, rf_p0, rf_p1, ex_result,
           mem_valid, mem_we, mem_dst_addr, mem_fwd_data, freeze, flush,
    input  id_stall, ex_valid, ex_op0, ex_op1, ex_dst_addr, ex_we, ex_is_load,
           stall_cnt
  );

  modport slave (
    input  id_valid, id_src0_addr, id_src1_addr, id_src0_used, id_src1_used,
           id_dst_addr, id_we, id_is_load, rf_p0, rf_p1, ex_result,
           mem_valid, mem_we, mem_dst_addr, mem_fwd_data, freeze, flush,
    output id_stall, ex_valid, ex_op0, ex_op1, ex_dst_addr, ex_we, ex_is_load,
           stall_cnt
  );

endinterface

// File: rtl/id_ex_fwd_stage_fwd_mux.sv
// One operand's bypass: compares the source register against in-flight writers and picks the youngest.
module fwd_mux
  #(parameter int unsigned DATA_W = cpu_pkg::DATA_W,
    parameter int unsigned ADDR_W = cpu_pkg::ADDR_W)
  (
    input  logic [ADDR_W-1:0] src_addr,
    input  logic              ex_fwd_en,
    input  logic [ADDR_W-1:0] ex_dst_addr,
    input  logic [DATA_W-1:0] ex_data,
    input  logic              mem_fwd_en,
    input  logic [ADDR_W-1:0] mem_dst_addr,
    input  logic [DATA_W-1:0] mem_data,
    input  logic [DATA_W-1:0] rf_data,
    output logic [DATA_W-1:0] op
  );
  import cpu_pkg::*;

  fwd_sel_e sel;

  // R0 check comes first so a write to R0 in flight can never leak through.
  always_comb begin
    sel = FWD_RF;
    if (src_addr == ADDR_W'(REG_ZERO))
      sel = FWD_ZERO;
    else if (ex_fwd_en && (src_addr == ex_dst_addr))
      sel = FWD_EX;
    else if (mem_fwd_en && (src_addr == mem_dst_addr))
      sel = FWD_MEM;
  end

  always_comb begin
    op = rf_data;
    case (sel)
      FWD_ZERO: op = '0;
      FWD_EX:   op = ex_data;
      FWD_MEM:  op = mem_data;
      default:  op = rf_data;
    endcase
  end

endmodule

// File: rtl/id_ex_fwd_stage.sv
// ID/EX pipeline register with EX/MEM operand bypass and load-use bubble insertion.
module id_ex_fwd_stage
  #(parameter int unsigned DATA_W      = cpu_pkg::DATA_W,
    parameter int unsigned ADDR_W      = cpu_pkg::ADDR_W,
    parameter int unsigned STALL_CNT_W = cpu_pkg::STALL_CNT_W)
  (
    input  logic               clk,
    input  logic               rst,
    id_ex_fwd_stage_if.slave   bus
  );
  import cpu_pkg::*;

  logic                   ex_valid_q;
  logic [DATA_W-1:0]      ex_op0_q;
  logic [DATA_W-1:0]      ex_op1_q;
  logic [ADDR_W-1:0]      ex_dst_q;
  logic                   ex_we_q;
  logic                   ex_is_load_q;
  logic [STALL_CNT_W-1:0] stall_cnt_q;

  logic                   ex_fwd_en;
  logic                   mem_fwd_en;
  logic                   hazard;
  logic [DATA_W-1:0]      op0_nxt;
  logic [DATA_W-1:0]      op1_nxt;

  // Load data is not available until MEM, so a load in EX is never a bypass source.
  assign ex_fwd_en  = ex_valid_q & ex_we_q & ~ex_is_load_q;
  assign mem_fwd_en = bus.mem_valid & bus.mem_we;

  assign hazard = bus.id_valid & ex_valid_q & ex_is_load_q & ex_we_q
                & (ex_dst_q != ADDR_W'(REG_ZERO))
                & ((bus.id_src0_used & (bus.id_src0_addr == ex_dst_q))
                 | (bus.id_src1_used & (bus.id_src1_addr == ex_dst_q)));

  fwd_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fwd_op0 (
    .src_addr     (bus.id_src0_addr),
    .ex_fwd_en    (ex_fwd_en),
    .ex_dst_addr  (ex_dst_q),
    .ex_data      (bus.ex_result),
    .mem_fwd_en   (mem_fwd_en),
    .mem_dst_addr (bus.mem_dst_addr),
    .mem_data     (bus.mem_fwd_data),
    .rf_data      (bus.rf_p0),
    .op           (op0_nxt)
  );

  fwd_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fwd_op1 (
    .src_addr     (bus.id_src1_addr),
    .ex_fwd_en    (ex_fwd_en),
    .ex_dst_addr  (ex_dst_q),
    .ex_data      (bus.ex_result),
    .mem_fwd_en   (mem_fwd_en),
    .mem_dst_addr (bus.mem_dst_addr),
    .mem_data     (bus.mem_fwd_data),
    .rf_data      (bus.rf_p1),
    .op           (op1_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q   <= 1'b0;
      ex_op0_q     <= '0;
      ex_op1_q     <= '0;
      ex_dst_q     <= '0;
      ex_we_q      <= 1'b0;
      ex_is_load_q <= 1'b0;
      stall_cnt_q  <= '0;
    end else if (bus.flush) begin
      ex_valid_q   <= 1'b0;
      ex_we_q      <= 1'b0;
      ex_is_load_q <= 1'b0;
    end else if (bus.freeze) begin
      ex_valid_q   <= ex_valid_q;
    end else if (hazard) begin
      ex_valid_q   <= 1'b0;
      ex_we_q      <= 1'b0;
      ex_is_load_q <= 1'b0;
      if (stall_cnt_q != '1)
        stall_cnt_q <= stall_cnt_q + 1'b1;
    end else begin
      ex_valid_q   <= bus.id_valid;
      ex_op0_q     <= op0_nxt;
      ex_op1_q     <= op1_nxt;
      ex_dst_q     <= bus.id_dst_addr;
      ex_we_q      <= bus.id_we & bus.id_valid;
      ex_is_load_q <= bus.id_is_load;
    end
  end

  assign bus.id_stall    = hazard | bus.freeze;
  assign bus.ex_valid    = ex_valid_q;
  assign bus.ex_op0      = ex_op0_q;
  assign bus.ex_op1      = ex_op1_q;
  assign bus.ex_dst_addr = ex_dst_q;
  assign bus.ex_we       = ex_we_q;
  assign bus.ex_is_load  = ex_is_load_q;
  assign bus.stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_fwd_stage.sv
// Scoreboard bench for id_ex_fwd_stage: directed pipeline scenarios followed by random traffic.
module tb_id_ex_fwd_stage;
  localparam int unsigned DW = 16;
  localparam int unsigned AW = 4;
  localparam int unsigned CW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_ex_fwd_stage_if #(.DATA_W(DW), .ADDR_W(AW), .STALL_CNT_W(CW)) bus ();

  id_ex_fwd_stage #(.DATA_W(DW), .ADDR_W(AW), .STALL_CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic          valid;
    logic          we;
    logic          load;
    logic [AW-1:0] dst;
    logic [DW-1:0] op0;
    logic [DW-1:0] op1;
    logic [CW-1:0] cnt;
    bit            known;
  } exp_t;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  exp_t m = '{valid: 1'b0, we: 1'b0, load: 1'b0, dst: '0, op0: '0, op1: '0, cnt: '0, known: 1'b1};
  bit   m_init = 1'b0;
  exp_t state_q[$];
  int   stall_q[$];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Value an operand should carry: zero for R0, else the youngest in-flight writer, else the RF.
  function automatic logic [DW-1:0] pick(input logic [AW-1:0] a, input logic [DW-1:0] rf);
    wr_t w[$];
    if (a == 0) return '0;
    if (m.valid && m.we && !m.load) w.push_back('{a: m.dst, d: bus.ex_result});
    if (bus.mem_valid && bus.mem_we) w.push_back('{a: bus.mem_dst_addr, d: bus.mem_fwd_data});
    foreach (w[i]) if (w[i].a == a) return w[i].d;
    return rf;
  endfunction

  task automatic idle();
    rst = 1'b0;
    bus.id_valid = 0; bus.id_src0_addr = 0; bus.id_src1_addr = 0;
    bus.id_src0_used = 0; bus.id_src1_used = 0; bus.id_dst_addr = 0;
    bus.id_we = 0; bus.id_is_load = 0;
    bus.rf_p0 = DW'($urandom); bus.rf_p1 = DW'($urandom);
    bus.ex_result = DW'($urandom); bus.mem_fwd_data = DW'($urandom);
    bus.mem_valid = 0; bus.mem_we = 0; bus.mem_dst_addr = 0;
    bus.freeze = 0; bus.flush = 0;
  endtask

  task automatic nxt();
    @(negedge clk);
    idle();
  endtask

  // Inputs for this cycle are already applied; predict id_stall now and the state after the edge.
  task automatic step();
    logic hz;
    exp_t n;
    hz = bus.id_valid && m.valid && m.load && m.we && (m.dst != 0) &&
         ((bus.id_src0_used && bus.id_src0_addr == m.dst) ||
          (bus.id_src1_used && bus.id_src1_addr == m.dst));
    stall_q.push_back(m_init ? int'(hz || bus.freeze) : 2);
    n = m;
    if (rst) begin
      n = '{valid: 1'b0, we: 1'b0, load: 1'b0, dst: '0, op0: '0, op1: '0, cnt: '0, known: 1'b1};
    end else if (bus.flush) begin
      n.valid = 0; n.we = 0; n.load = 0; n.known = 0;
    end else if (bus.freeze) begin
      n = m;
    end else if (hz) begin
      n.valid = 0; n.we = 0; n.load = 0; n.known = 0;
      n.cnt = (m.cnt == '1) ? m.cnt : m.cnt + 1'b1;
    end else begin
      n.valid = bus.id_valid;
      n.we    = bus.id_we && bus.id_valid;
      n.load  = bus.id_is_load;
      n.dst   = bus.id_dst_addr;
      n.op0   = pick(bus.id_src0_addr, bus.rf_p0);
      n.op1   = pick(bus.id_src1_addr, bus.rf_p1);
      n.known = 1;
    end
    state_q.push_back(n);
    m = n;
    m_init = 1;
  endtask

  task automatic issue(input logic [AW-1:0] dst, input logic we, input logic ld,
                       input logic [AW-1:0] s0, input logic u0,
                       input logic [AW-1:0] s1, input logic u1);
    bus.id_valid = 1; bus.id_dst_addr = dst; bus.id_we = we; bus.id_is_load = ld;
    bus.id_src0_addr = s0; bus.id_src0_used = u0;
    bus.id_src1_addr = s1; bus.id_src1_used = u1;
  endtask

  initial begin : monitor
    int   s;
    exp_t e;
    forever begin
      @(negedge clk); #3;
      if (stall_q.size() > 0) begin
        s = stall_q.pop_front();
        if (s != 2) chk("id_stall", 32'(bus.id_stall), 32'(s));
      end
      @(posedge clk); #1;
      if (state_q.size() > 0) begin
        e = state_q.pop_front();
        chk("ex_valid", 32'(bus.ex_valid), 32'(e.valid));
        chk("ex_we", 32'(bus.ex_we), 32'(e.we));
        chk("ex_is_load", 32'(bus.ex_is_load), 32'(e.load));
        chk("stall_cnt", 32'(bus.stall_cnt), 32'(e.cnt));
        if (e.known) begin
          chk("ex_dst_addr", 32'(bus.ex_dst_addr), 32'(e.dst));
          chk("ex_op0", 32'(bus.ex_op0), 32'(e.op0));
          chk("ex_op1", 32'(bus.ex_op1), 32'(e.op1));
        end
      end
    end
  end

  initial begin : stimulus
    idle();
    rst = 1'b1;
    repeat (2) begin nxt(); rst = 1'b1; step(); end

    // ADD R3 then reader of R3: EX bypass
    nxt(); issue(3, 1, 0, 0, 0, 0, 0); step();
    nxt(); issue(4, 1, 0, 3, 1, 0, 0); bus.ex_result = 16'h1234; step();
    // EX and MEM both hold R3: EX wins
    nxt(); issue(3, 1, 0, 0, 0, 0, 0); step();
    nxt(); issue(6, 1, 0, 3, 1, 3, 1); bus.ex_result = 16'h1111;
    bus.mem_valid = 1; bus.mem_we = 1; bus.mem_dst_addr = 3; bus.mem_fwd_data = 16'h2222; step();
    // LW R5, dependent reader: one bubble, then load data from MEM
    nxt(); issue(5, 1, 1, 0, 0, 0, 0); step();
    nxt(); issue(7, 1, 0, 2, 0, 5, 1); step();
    nxt(); issue(7, 1, 0, 2, 0, 5, 1);
    bus.mem_valid = 1; bus.mem_we = 1; bus.mem_dst_addr = 5; bus.mem_fwd_data = 16'hBEEF; step();
    // R0 writes never forward, LW R0 never stalls
    nxt(); issue(0, 1, 0, 0, 0, 0, 0); step();
    nxt(); issue(2, 1, 0, 0, 1, 0, 1); bus.ex_result = 16'hFFFF; step();
    nxt(); issue(0, 1, 1, 0, 0, 0, 0); step();
    nxt(); issue(2, 1, 0, 0, 1, 0, 1); step();
    // flush with freeze, then freeze during a hazard
    nxt(); issue(8, 1, 0, 1, 1, 2, 1); step();
    nxt(); issue(9, 1, 0, 1, 1, 2, 1); bus.flush = 1; bus.freeze = 1; step();
    nxt(); issue(6, 1, 1, 0, 0, 0, 0); step();
    nxt(); issue(9, 1, 0, 6, 1, 0, 0); bus.freeze = 1; step();
    nxt(); issue(9, 1, 0, 6, 1, 0, 0); step();
    nxt(); issue(9, 1, 0, 6, 1, 0, 0); step();
    // unused source matching the load never stalls
    nxt(); issue(6, 1, 1, 0, 0, 0, 0); step();
    nxt(); issue(9, 1, 0, 6, 0, 6, 0); step();
    // drive the counter into saturation
    for (int i = 0; i < 20; i++) begin
      nxt(); issue(5, 1, 1, 0, 0, 0, 0); step();
      nxt(); issue(1, 1, 0, 5, 1, 0, 0); step();
    end
    // reset mid-run with EX occupied
    nxt(); issue(4, 1, 0, 0, 0, 0, 0); step();
    nxt(); issue(4, 1, 0, 0, 0, 0, 0); rst = 1'b1; step();

    for (int i = 0; i < 3000; i++) begin
      nxt();
      bus.id_valid     = ($urandom_range(0, 9) < 8);
      bus.id_src0_addr = AW'($urandom_range(0, 3));
      bus.id_src1_addr = AW'($urandom_range(0, 3));
      bus.id_src0_used = 1'($urandom);
      bus.id_src1_used = 1'($urandom);
      bus.id_dst_addr  = AW'($urandom_range(0, 3));
      bus.id_we        = ($urandom_range(0, 9) < 7);
      bus.id_is_load   = ($urandom_range(0, 9) < 3);
      bus.mem_valid    = 1'($urandom);
      bus.mem_we       = 1'($urandom);
      bus.mem_dst_addr = AW'($urandom_range(0, 3));
      bus.flush        = ($urandom_range(0, 19) == 0);
      bus.freeze       = ($urandom_range(0, 9) == 0);
      rst              = ($urandom_range(0, 199) == 0);
      step();
    end

    nxt();
    step();
    repeat (6) @(posedge clk);
    if (state_q.size() != 0 || stall_q.size() != 0)
      chk("scoreboard_drain", 32'(state_q.size() + stall_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
